// File: rtl/alu_load_sequencer.sv
// Byte-stream loader for the shared 8-bit ALU: captures A, B and opcode bytes, waits a settle
// time, registers the ALU result and offers it on a valid/ready port, with optional chaining.
module alu_load_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_result,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StLoadOp,
        StExec,
        StDone
    } state_t;

    localparam logic [3:0] LastCnt = 4'(EXEC_CYCLES - 1);

    state_t     state_q;
    logic       chain_q;
    logic [3:0] cnt_q;

    // Handshake flags depend on the state alone so upstream never sees a combinational path.
    assign in_ready = (state_q == StLoadA) || (state_q == StLoadB) || (state_q == StLoadOp);
    assign busy     = (state_q != StLoadA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StLoadA;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_opcode <= 4'h0;
            chain_q    <= 1'b0;
            cnt_q      <= 4'h0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
        end else begin
            unique case (state_q)
                StLoadA: begin
                    if (in_valid) begin
                        alu_a   <= in_data;
                        state_q <= StLoadB;
                    end
                end
                StLoadB: begin
                    if (in_valid) begin
                        alu_b   <= in_data;
                        state_q <= StLoadOp;
                    end
                end
                StLoadOp: begin
                    if (in_valid) begin
                        alu_opcode <= in_data[3:0];
                        chain_q    <= in_data[7];
                        cnt_q      <= 4'h0;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    if (cnt_q == LastCnt) begin
                        out_data  <= alu_result;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 4'h1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Chained sequences reuse the result as A and skip the A byte.
                        if (chain_q) begin
                            alu_a   <= out_data;
                            state_q <= StLoadB;
                        end else begin
                            state_q <= StLoadA;
                        end
                    end
                end
                default: state_q <= StLoadA;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Self-checking bench for alu_load_sequencer: vector table, scoreboard of expected results and
// hand-written sequences for backpressure, chaining, long settle time and asynchronous reset.
module tb_alu_load_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] alu_a, alu_b, alu_result, out_data;
    logic [3:0] alu_opcode;
    logic       out_valid, busy;
    logic       out_ready = 1'b1;

    logic       in_valid4 = 1'b0;
    logic [7:0] in_data4 = 8'h00;
    logic       in_ready4;
    logic [7:0] alu_a4, alu_b4, alu_result4, out_data4;
    logic [3:0] alu_opcode4;
    logic       out_valid4, busy4;
    logic       out_ready4 = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] op);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result  = alu_model(alu_a, alu_b, alu_opcode);
    always_comb alu_result4 = alu_model(alu_a4, alu_b4, alu_opcode4);

    alu_load_sequencer #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
    );

    alu_load_sequencer #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_opcode4), .alu_result(alu_result4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4), .busy(busy4)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard: a result is popped on the cycle its output transfer will happen.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                check("result", out_data, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send_byte");
    endtask

    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp);
        exp_q.push_back(exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cnt;
        bit ok;
        vecs[0] = '{a: 8'hF0, b: 8'h20, op: 8'h00, exp: 8'h10};
        vecs[1] = '{a: 8'h50, b: 8'h30, op: 8'h01, exp: 8'h20};
        vecs[2] = '{a: 8'hF0, b: 8'h3C, op: 8'h02, exp: 8'h30};
        vecs[3] = '{a: 8'hF0, b: 8'h0F, op: 8'h03, exp: 8'hFF};
        vecs[4] = '{a: 8'hAA, b: 8'hFF, op: 8'h74, exp: 8'h55};
        vecs[5] = '{a: 8'h10, b: 8'h20, op: 8'h09, exp: 8'h00};

        // Reset state
        #2;
        check("rst_in_ready", {7'd0, in_ready}, 8'h01);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check("rst_out_data", out_data, 8'h00);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_opcode", {4'h0, alu_opcode}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic add: out_valid high exactly one cycle with out_ready held
        run_seq(8'h12, 8'h34, 8'h00, 8'h46);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("valid_cycles", 8'(cnt), 8'd1);
        @(posedge clk);
        #1;
        check("idle_in_ready", {7'd0, in_ready}, 8'h01);
        check("idle_busy", {7'd0, busy}, 8'h00);

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
            wait_drain();
            check("vec_idle_busy", {7'd0, busy}, 8'h00);
        end

        // Backpressure: result held, pending byte not consumed
        out_ready = 1'b0;
        run_seq(8'h01, 8'h02, 8'h00, 8'h03);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("bp_valid");
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {7'd0, out_valid}, 8'h01);
            check("bp_out_data", out_data, 8'h03);
            check("bp_in_ready", {7'd0, in_ready}, 8'h00);
            check("bp_alu_a", alu_a, 8'h01);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_xfer_valid", {7'd0, out_valid}, 8'h00);
        @(posedge clk);
        #1;
        check("bp_new_a", alu_a, 8'h55);
        check("bp_new_busy", {7'd0, busy}, 8'h01);
        exp_q.push_back(8'h66);
        send_byte(8'h11);
        send_byte(8'h00);
        in_valid = 1'b0;
        wait_drain();

        // Chain: result reused as A
        run_seq(8'h05, 8'h03, 8'h80, 8'h08);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("chain_in_ready_low", {7'd0, in_ready}, 8'h00);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("chain_valid");
        @(posedge clk);
        #1;
        check("chain_busy", {7'd0, busy}, 8'h01);
        check("chain_in_ready", {7'd0, in_ready}, 8'h01);
        check("chain_alu_a", alu_a, 8'h08);
        exp_q.push_back(8'h0A);
        send_byte(8'h02);
        send_byte(8'h00);
        in_valid = 1'b0;
        wait_drain();
        check("chain_end_busy", {7'd0, busy}, 8'h00);

        // EXEC_CYCLES=4 instance: result appears 4 edges after opcode
        in_valid4 = 1'b1;
        in_data4  = 8'h07;
        @(posedge clk);
        #1;
        in_data4 = 8'h09;
        @(posedge clk);
        #1;
        in_data4 = 8'h00;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("x4_valid_low", {7'd0, out_valid4}, 8'h00);
            check("x4_alu_a", alu_a4, 8'h07);
            check("x4_alu_b", alu_b4, 8'h09);
            check("x4_alu_op", {4'h0, alu_opcode4}, 8'h00);
        end
        @(negedge clk);
        check("x4_valid_high", {7'd0, out_valid4}, 8'h01);
        check("x4_out_data", out_data4, 8'h10);
        @(posedge clk);
        #1;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        check("x4_done_valid", {7'd0, out_valid4}, 8'h00);
        check("x4_done_busy", {7'd0, busy4}, 8'h00);

        // Asynchronous reset mid-sequence
        send_byte(8'hAA);
        send_byte(8'hBB);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_in_ready", {7'd0, in_ready}, 8'h01);
        check("arst_busy", {7'd0, busy}, 8'h00);
        check("arst_out_valid", {7'd0, out_valid}, 8'h00);
        check("arst_out_data", out_data, 8'h00);
        check("arst_alu_a", alu_a, 8'h00);
        check("arst_alu_b", alu_b, 8'h00);
        check("arst_alu_opcode", {4'h0, alu_opcode}, 8'h00);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_seq(8'h01, 8'h01, 8'h00, 8'h02);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
